gemm_seq: RTL and testbench
===========================

GEMM_SEQ -- requirements
Module: gemm_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning buffer words per phase (power of two, max 64).
REQ-002 SHALL have parameter AW, default 6, meaning buffer address width, equal to log2(DEPTH).
REQ-003 SHALL have port AXIS_ACLK, input, 1, the single clock.
REQ-004 SHALL have port AXIS_ARESETN, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have AXI-Lite write ports: S_AXI_AWADDR in 32 (bits [3:2] decoded); S_AXI_AWVALID in 1; S_AXI_AWREADY out 1; S_AXI_WDATA in 32; S_AXI_WVALID in 1; S_AXI_WREADY out 1; S_AXI_BVALID out 1; S_AXI_BREADY in 1; S_AXI_BRESP out 2.
REQ-006 SHALL have stream-in control ports: S_AXIS_TVALID in 1; S_AXIS_TLAST in 1; S_AXIS_TREADY out 1; buf_we out 1 (buffer write strobe); buf_waddr out AW (buffer write address).
REQ-007 SHALL have compute control ports: calc_en out 1 (MAC step enable); calc_first out 1 (clear accumulators); calc_idx out 8 (current k index).
REQ-008 SHALL have stream-out control ports: out_raddr out AW (async-read result address); M_AXIS_TVALID out 1; M_AXIS_TLAST out 1; M_AXIS_TREADY in 1; busy out 1.

Function
REQ-009 SHALL decode registers: 0x0 CTRL (bit0 start, write-1 pulse; bit1 irq clear); 0x4 NLOAD [6:0]; 0x8 NOUT [6:0]; 0xC K [7:0].
REQ-010 SHALL drive S_AXI_AWREADY = S_AXI_WREADY = AWVALID & WVALID & ~BVALID, combinationally, so a one-cycle AW+W pulse is accepted.
REQ-011 SHALL raise BVALID the cycle after acceptance, hold it until BREADY, and drive BRESP fixed at 0.
REQ-012 SHALL latch NLOAD/NOUT/K into working copies on start; register writes during busy update only the registers.
REQ-013 SHALL clamp NLOAD/NOUT values of 0 to 1 and values above DEPTH to DEPTH, and treat K = 0 as 1.
REQ-014 SHALL implement FSM IDLE -> LOAD -> CALC -> DRAIN -> IDLE; start is accepted only in IDLE and is ignored otherwise.
REQ-015 SHALL drive busy high in every state except IDLE.
REQ-016 In LOAD, SHALL hold S_AXIS_TREADY = 1 and buf_we = TVALID & TREADY, with buf_waddr counting 0..NLOAD-1.
REQ-017 SHALL leave LOAD on the beat after NLOAD handshakes, or early on a handshake carrying S_AXIS_TLAST.
REQ-018 In CALC, SHALL hold calc_en for exactly K cycles with calc_idx 0..K-1, and drive calc_first only at idx 0.
REQ-019 In DRAIN, SHALL hold M_AXIS_TVALID = 1, and advance out_raddr 0..NOUT-1 on each TVALID & TREADY.
REQ-020 SHALL hold out_raddr and TVALID stable while TREADY is low.
REQ-021 SHALL assert M_AXIS_TLAST only with out_raddr = NOUT-1, and enter IDLE after that handshake.
REQ-022 SHALL insert no idle cycles between phases other than the single FSM transition cycle.

Reset
REQ-023 SHALL, while AXIS_ARESETN is low, immediately force all outputs to 0 and the FSM to IDLE.
REQ-024 SHALL reset registers NLOAD = NOUT = DEPTH and K = 1.
REQ-025 SHALL, on reset mid-operation, abandon the job with no TLAST emitted.

Configuration
REQ-026 With GEMM_SEQ_IRQ_EN defined, SHALL add output irq (1 bit), set on the cycle DRAIN exits, cleared by writing CTRL bit1.
REQ-027 When an irq set and an irq clear occur in the same cycle, set SHALL win.
REQ-028 Without GEMM_SEQ_IRQ_EN, the irq port and its logic SHALL be absent, and CTRL bit1 SHALL be ignored.

Structure
REQ-029 SHALL place register offsets, FSM state enum and DEPTH default in package gemm_pkg.
REQ-030 SHALL instantiate sub-module gemm_seq_regs, containing the AXI-Lite write slave and registers and outputting a start pulse and latched config.

Verification
REQ-031 Write NLOAD=4, NOUT=4, K=4, CTRL=1, then send 4 beats -> buf_waddr 0..3, calc_en 4 cycles, 4 output beats with TLAST on beat 3.
REQ-032 In DRAIN, hold TREADY low for 3 cycles at beat 1 -> out_raddr stays 1 and TVALID stays high; beat count is unchanged.
REQ-033 Set NLOAD=8 and send TLAST on beat 2 -> LOAD exits after 3 writes and CALC starts.
REQ-034 Write CTRL=1 during CALC and write NOUT=2 -> no restart, and the current job still outputs the latched NOUT.
REQ-035 Write NLOAD=0, NOUT=100, K=0 -> 1 load beat, 1 calc cycle, 64 output beats.
REQ-036 Deassert AXIS_ARESETN mid-LOAD, then restart a job -> busy=0 immediately, and the next job completes normally; with GEMM_SEQ_IRQ_EN, irq sets at the end of that job and clears on a CTRL=2 write.

Source files
------------

// File: rtl/gemm_pkg.sv
// Shared constants, register map, FSM states and latched job config for the GEMM sequencer.
package gemm_pkg;

  localparam int unsigned DEPTH_DEF = 64;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned LEN_W     = 7;
  localparam int unsigned IDX_W     = 6;

  localparam logic [1:0] REG_CTRL  = 2'd0;
  localparam logic [1:0] REG_NLOAD = 2'd1;
  localparam logic [1:0] REG_NOUT  = 2'd2;
  localparam logic [1:0] REG_K     = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CALC  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Job config stored as last index of each phase (count - 1)
  typedef struct packed {
    logic [CNT_W-1:0] k_last;
    logic [IDX_W-1:0] nout_last;
    logic [IDX_W-1:0] nload_last;
  } cfg_t;

  // Clamp a beat count into 1..depth and return it as a last index
  function automatic logic [IDX_W-1:0] clamp_last(input logic [LEN_W-1:0] v,
                                                  input logic [LEN_W-1:0] depth);
    if (v == '0) return '0;
    if (v > depth) return IDX_W'(depth - LEN_W'(1));
    return IDX_W'(v - LEN_W'(1));
  endfunction

endpackage

// File: rtl/gemm_seq_regs.sv
// AXI-Lite write slave, config registers and job-config latch for gemm_seq.
// GEMM_SEQ_IRQ_EN adds the CTRL bit1 irq-clear strobe.
module gemm_seq_regs
  import gemm_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic        wvalid,
  output logic        wready,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  input  logic        idle,
  output logic        start_c,
`ifdef GEMM_SEQ_IRQ_EN
  output logic        irq_clr_c,
`endif
  output cfg_t        cfg
);

  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  logic             wr_fire_c;
  logic [1:0]       wsel;
  logic             bvalid_q;
  logic [LEN_W-1:0] nload_q;
  logic [LEN_W-1:0] nout_q;
  logic [CNT_W-1:0] k_q;
  logic             unused_c;

  // AW and W accepted together in one beat; reset keeps the handshake low
  assign wr_fire_c = rst_n & awvalid & wvalid & ~bvalid_q;
  assign awready   = wr_fire_c;
  assign wready    = wr_fire_c;
  assign bvalid    = bvalid_q;
  assign bresp     = 2'b00;
  assign wsel      = awaddr[3:2];
  assign start_c   = wr_fire_c && (wsel == REG_CTRL) && wdata[0];
`ifdef GEMM_SEQ_IRQ_EN
  assign irq_clr_c = wr_fire_c && (wsel == REG_CTRL) && wdata[1];
`endif
  assign unused_c  = ^{awaddr[31:4], awaddr[1:0], wdata[31:8]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bvalid_q <= 1'b0;
    end else if (wr_fire_c) begin
      bvalid_q <= 1'b1;
    end else if (bready) begin
      bvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nload_q <= DEPTH_L;
      nout_q  <= DEPTH_L;
      k_q     <= CNT_W'(1);
    end else if (wr_fire_c) begin
      case (wsel)
        REG_NLOAD: nload_q <= wdata[LEN_W-1:0];
        REG_NOUT:  nout_q  <= wdata[LEN_W-1:0];
        REG_K:     k_q     <= wdata[CNT_W-1:0];
        default:   ;
      endcase
    end
  end

  // Working copy only refreshes on an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg <= '0;
    end else if (start_c && idle) begin
      cfg.nload_last <= clamp_last(nload_q, DEPTH_L);
      cfg.nout_last  <= clamp_last(nout_q, DEPTH_L);
      cfg.k_last     <= (k_q == '0) ? '0 : k_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/gemm_seq.sv
// GEMM job sequencer: LOAD stream-in, CALC MAC steps, DRAIN stream-out.
// GEMM_SEQ_IRQ_EN adds a sticky completion irq output.
module gemm_seq
  import gemm_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = 6
) (
  input  logic          AXIS_ACLK,
  input  logic          AXIS_ARESETN,
  input  logic [31:0]   S_AXI_AWADDR,
  input  logic          S_AXI_AWVALID,
  output logic          S_AXI_AWREADY,
  input  logic [31:0]   S_AXI_WDATA,
  input  logic          S_AXI_WVALID,
  output logic          S_AXI_WREADY,
  output logic          S_AXI_BVALID,
  input  logic          S_AXI_BREADY,
  output logic [1:0]    S_AXI_BRESP,
  input  logic          S_AXIS_TVALID,
  input  logic          S_AXIS_TLAST,
  output logic          S_AXIS_TREADY,
  output logic          buf_we,
  output logic [AW-1:0] buf_waddr,
  output logic          calc_en,
  output logic          calc_first,
  output logic [7:0]    calc_idx,
  output logic [AW-1:0] out_raddr,
  output logic          M_AXIS_TVALID,
  output logic          M_AXIS_TLAST,
  input  logic          M_AXIS_TREADY,
  output logic          busy
`ifdef GEMM_SEQ_IRQ_EN
  ,
  output logic          irq
`endif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_c;
  logic             idle_c;
  cfg_t             cfg;
`ifdef GEMM_SEQ_IRQ_EN
  logic             irq_clr_c;
  logic             drain_done_c;
  logic             irq_q;
`endif

  assign idle_c = (state_q == ST_IDLE);

  gemm_seq_regs #(.DEPTH(DEPTH)) u_regs (
    .clk       (AXIS_ACLK),
    .rst_n     (AXIS_ARESETN),
    .awaddr    (S_AXI_AWADDR),
    .awvalid   (S_AXI_AWVALID),
    .awready   (S_AXI_AWREADY),
    .wdata     (S_AXI_WDATA),
    .wvalid    (S_AXI_WVALID),
    .wready    (S_AXI_WREADY),
    .bvalid    (S_AXI_BVALID),
    .bready    (S_AXI_BREADY),
    .bresp     (S_AXI_BRESP),
    .idle      (idle_c),
    .start_c   (start_c),
`ifdef GEMM_SEQ_IRQ_EN
    .irq_clr_c (irq_clr_c),
`endif
    .cfg       (cfg)
  );

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // One shared index counter serves every phase; it is zero on each phase entry
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    S_AXIS_TREADY = 1'b0;
    buf_we        = 1'b0;
    calc_en       = 1'b0;
    calc_first    = 1'b0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TLAST  = 1'b0;
    busy          = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        S_AXIS_TREADY = 1'b1;
        buf_we        = S_AXIS_TVALID;
        if (S_AXIS_TVALID) begin
          if (S_AXIS_TLAST || (cnt_q == CNT_W'(cfg.nload_last))) begin
            state_d = ST_CALC;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_CALC: begin
        calc_en    = 1'b1;
        calc_first = (cnt_q == '0);
        if (cnt_q == cfg.k_last) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TLAST  = (cnt_q == CNT_W'(cfg.nout_last));
        if (M_AXIS_TREADY) begin
          if (M_AXIS_TLAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign calc_idx  = cnt_q;
  assign buf_waddr = AW'(cnt_q);
  assign out_raddr = AW'(cnt_q);

`ifdef GEMM_SEQ_IRQ_EN
  assign drain_done_c = (state_q == ST_DRAIN) && M_AXIS_TREADY && M_AXIS_TLAST;

  // Set takes priority over a clear in the same cycle
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      irq_q <= 1'b0;
    end else if (drain_done_c) begin
      irq_q <= 1'b1;
    end else if (irq_clr_c) begin
      irq_q <= 1'b0;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_gemm_seq.sv
// Self-checking bench for gemm_seq: randomized jobs against a phase-level reference model.
module tb_gemm_seq;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   awaddr;
  logic          awvalid;
  logic          awready;
  logic [31:0]   wdata;
  logic          wvalid;
  logic          wready;
  logic          bvalid;
  logic          bready;
  logic [1:0]    bresp;
  logic          s_tvalid;
  logic          s_tlast;
  logic          s_tready;
  logic          buf_we;
  logic [AW-1:0] buf_waddr;
  logic          calc_en;
  logic          calc_first;
  logic [7:0]    calc_idx;
  logic [AW-1:0] out_raddr;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready;
  logic          busy;
`ifdef GEMM_SEQ_IRQ_EN
  logic          irq;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model of the programmed register values
  int m_nload, m_nout, m_k;

  // Observed activity, captured once per cycle
  int   load_q[$];
  int   load_cyc[$];
  int   calc_q[$];
  logic calc_first_q[$];
  int   calc_cyc[$];
  int   out_q[$];
  logic out_last_q[$];
  int   first_tv_cyc;

  always #5 clk = ~clk;

  gemm_seq #(.DEPTH(DEPTH), .AW(AW)) dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESETN  (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_BRESP   (bresp),
    .S_AXIS_TVALID (s_tvalid),
    .S_AXIS_TLAST  (s_tlast),
    .S_AXIS_TREADY (s_tready),
    .buf_we        (buf_we),
    .buf_waddr     (buf_waddr),
    .calc_en       (calc_en),
    .calc_first    (calc_first),
    .calc_idx      (calc_idx),
    .out_raddr     (out_raddr),
    .M_AXIS_TVALID (m_tvalid),
    .M_AXIS_TLAST  (m_tlast),
    .M_AXIS_TREADY (m_tready),
    .busy          (busy)
`ifdef GEMM_SEQ_IRQ_EN
    ,
    .irq           (irq)
`endif
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (buf_we) begin
        load_q.push_back(int'(buf_waddr));
        load_cyc.push_back(cyc);
      end
      if (calc_en) begin
        calc_q.push_back(int'(calc_idx));
        calc_first_q.push_back(calc_first);
        calc_cyc.push_back(cyc);
      end
      if (m_tvalid && first_tv_cyc < 0) first_tv_cyc = cyc;
      if (m_tvalid && m_tready) begin
        out_q.push_back(int'(out_raddr));
        out_last_q.push_back(m_tlast);
      end
    end
  end

  function automatic int eff_len(input int v);
    if (v == 0) return 1;
    if (v > DEPTH) return DEPTH;
    return v;
  endfunction

  task automatic clear_mon();
    load_q.delete(); load_cyc.delete();
    calc_q.delete(); calc_first_q.delete(); calc_cyc.delete();
    out_q.delete(); out_last_q.delete();
    first_tv_cyc = -1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    n_checks++;
    if (awready !== 1'b1 || wready !== 1'b1) begin
      n_fail++;
      $display("FAIL axi_accept addr=%0h: awready=%b wready=%b expected 1 1", addr, awready, wready);
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n_checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      n_fail++;
      $display("FAIL axi_bresp addr=%0h: bvalid=%b bresp=%0d expected 1 0", addr, bvalid, bresp);
    end
  endtask

  task automatic wr_reg(input logic [31:0] addr, input logic [31:0] data);
    case (addr)
      32'h4: m_nload = int'(data[6:0]);
      32'h8: m_nout  = int'(data[6:0]);
      32'hC: m_k     = int'(data[7:0]);
      default: ;
    endcase
    axi_write(addr, data);
  endtask

  task automatic drive_load(input int n, input int tlast_at);
    for (int i = 0; i < n; i++) begin
      int gap;
      int guard;
      @(posedge clk); #1;
      s_tvalid = 1'b0; s_tlast = 1'b0;
      gap = int'($urandom_range(0, 2));
      repeat (gap) begin @(posedge clk); #1; end
      s_tvalid = 1'b1;
      s_tlast  = (i == tlast_at);
      guard = 0;
      do begin @(negedge clk); guard++; end while (!s_tready && guard < 200);
      if (!s_tready) begin
        n_checks++; n_fail++;
        $display("FAIL load_timeout beat=%0d: s_tready=%b expected 1", i, s_tready);
        break;
      end
    end
    // Keep offering data after the last accepted beat; nothing more may be written
    @(posedge clk); #1;
    s_tlast = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    s_tvalid = 1'b0;
  endtask

  task automatic run_job(input int tlast_at, input int stall_beat, input int stall_len,
                         input bit mid_write, input string name);
    int nl_e, no_e, k_e, n_exp, beat, stalled, guard;
    bit done;
    logic r;
    nl_e  = eff_len(m_nload);
    no_e  = eff_len(m_nout);
    k_e   = (m_k == 0) ? 1 : m_k;
    n_exp = (tlast_at >= 0 && tlast_at < nl_e) ? tlast_at + 1 : nl_e;
    clear_mon();
`ifdef GEMM_SEQ_IRQ_EN
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL %s irq_idle: got %b expected 0", name, irq);
    end
`endif
    wr_reg(32'h0, 32'h1);
    drive_load(n_exp, tlast_at);
    if (mid_write) begin
      guard = 0;
      while (!calc_en && guard < 300) begin @(negedge clk); guard++; end
      n_checks++;
      if (calc_en !== 1'b1) begin
        n_fail++; $display("FAIL %s calc_wait: calc_en=%b expected 1", name, calc_en);
      end
      wr_reg(32'h0, 32'h1);
      wr_reg(32'h8, 32'h2);
    end
    guard = 0;
    while (!m_tvalid && guard < 1000) begin @(negedge clk); guard++; end
    beat = 0; stalled = 0; done = 1'b0; guard = 0;
    while (!done && guard < 2000) begin
      if (beat == stall_beat && stalled < stall_len) begin
        r = 1'b0; stalled++;
      end else begin
        r = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      m_tready = r;
      @(negedge clk);
      if (!r && beat == stall_beat && stall_len > 0) begin
        n_checks++;
        if (m_tvalid !== 1'b1 || int'(out_raddr) != beat) begin
          n_fail++;
          $display("FAIL %s stall_hold: tvalid=%b raddr=%0d expected 1 %0d", name, m_tvalid, out_raddr, beat);
        end
      end
      if (m_tvalid && m_tready) begin
        beat++;
        if (m_tlast) done = 1'b1;
      end
      guard++;
    end
    n_checks++;
    if (!done) begin
      n_fail++; $display("FAIL %s drain_timeout: beats=%0d expected %0d", name, beat, no_e);
    end
    @(posedge clk); #1;
    m_tready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL %s busy_end: got %b expected 0", name, busy);
    end

    n_checks++;
    if (load_q.size() != n_exp) begin
      n_fail++; $display("FAIL %s load_count: got %0d expected %0d", name, load_q.size(), n_exp);
    end
    foreach (load_q[i]) begin
      n_checks++;
      if (load_q[i] != i) begin
        n_fail++; $display("FAIL %s waddr[%0d]: got %0d expected %0d", name, i, load_q[i], i);
      end
    end
    n_checks++;
    if (calc_q.size() != k_e) begin
      n_fail++; $display("FAIL %s calc_count: got %0d expected %0d", name, calc_q.size(), k_e);
    end
    foreach (calc_q[i]) begin
      n_checks++;
      if (calc_q[i] != i || calc_first_q[i] !== 1'(i == 0)) begin
        n_fail++;
        $display("FAIL %s calc[%0d]: idx=%0d first=%b expected %0d %b", name, i, calc_q[i], calc_first_q[i], i, (i == 0));
      end
    end
    n_checks++;
    if (out_q.size() != no_e) begin
      n_fail++; $display("FAIL %s out_count: got %0d expected %0d", name, out_q.size(), no_e);
    end
    foreach (out_q[i]) begin
      n_checks++;
      if (out_q[i] != i || out_last_q[i] !== 1'(i == no_e - 1)) begin
        n_fail++;
        $display("FAIL %s out[%0d]: raddr=%0d tlast=%b expected %0d %b", name, i, out_q[i], out_last_q[i], i, (i == no_e - 1));
      end
    end
    if (load_cyc.size() > 0 && calc_cyc.size() > 0) begin
      n_checks++;
      if (calc_cyc[0] != load_cyc[load_cyc.size()-1] + 1 ||
          calc_cyc[calc_cyc.size()-1] - calc_cyc[0] != calc_cyc.size() - 1 ||
          first_tv_cyc != calc_cyc[calc_cyc.size()-1] + 1) begin
        n_fail++;
        $display("FAIL %s phase_gap: load_end=%0d calc=%0d..%0d drain=%0d expected back-to-back",
                 name, load_cyc[load_cyc.size()-1], calc_cyc[0], calc_cyc[calc_cyc.size()-1], first_tv_cyc);
      end
    end
`ifdef GEMM_SEQ_IRQ_EN
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL %s irq_set: got %b expected 1", name, irq);
    end
    axi_write(32'h0, 32'h2);
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL %s irq_clear: got %b expected 0", name, irq);
    end
`endif
  endtask

  task automatic test_reset();
    logic [31:0] v;
    awvalid = 1'b1; wvalid = 1'b1; s_tvalid = 1'b1; m_tready = 1'b1;
    repeat (3) @(negedge clk);
    v = {awready, wready, bvalid, bresp, s_tready, buf_we, buf_waddr, calc_en, calc_first,
         calc_idx, out_raddr, m_tvalid, m_tlast, busy};
    n_checks++;
    if (v !== 32'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", v);
    end
`ifdef GEMM_SEQ_IRQ_EN
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL reset_irq: got %b expected 0", irq);
    end
`endif
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0;
    rst_n = 1'b1;
    m_nload = DEPTH; m_nout = DEPTH; m_k = 1;
  endtask

  task automatic test_defaults();
    run_job(-1, -1, 0, 1'b0, "defaults");
  endtask

  task automatic test_basic();
    wr_reg(32'h4, 32'd4); wr_reg(32'h8, 32'd4); wr_reg(32'hC, 32'd4);
    run_job(-1, -1, 0, 1'b0, "basic");
  endtask

  task automatic test_stall();
    run_job(-1, 1, 3, 1'b0, "stall");
  endtask

  task automatic test_tlast_early();
    wr_reg(32'h4, 32'd8);
    run_job(2, -1, 0, 1'b0, "tlast_early");
  endtask

  task automatic test_bresp_hold();
    bready = 1'b0;
    wr_reg(32'hC, 32'd3);
    awaddr = 32'h4; wdata = 32'd5; awvalid = 1'b1; wvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) begin
        n_fail++;
        $display("FAIL bresp_hold: bvalid=%b awready=%b wready=%b expected 1 0 0", bvalid, awready, wready);
      end
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bvalid !== 1'b0) begin
      n_fail++; $display("FAIL bresp_release: bvalid=%b expected 0", bvalid);
    end
    run_job(-1, -1, 0, 1'b0, "k3_job");
  endtask

  task automatic test_start_during_busy();
    wr_reg(32'h4, 32'd4); wr_reg(32'h8, 32'd4); wr_reg(32'hC, 32'd20);
    run_job(-1, -1, 0, 1'b1, "start_busy");
    run_job(-1, -1, 0, 1'b0, "nout_updated");
  endtask

  task automatic test_clamp();
    wr_reg(32'h4, 32'd0); wr_reg(32'h8, 32'd100); wr_reg(32'hC, 32'd0);
    run_job(-1, -1, 0, 1'b0, "clamp");
  endtask

  task automatic test_ctrl_bit1();
    axi_write(32'h0, 32'h2);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL ctrl_bit1_no_start: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    wr_reg(32'h4, 32'd8); wr_reg(32'h8, 32'd4); wr_reg(32'hC, 32'd2);
    clear_mon();
    wr_reg(32'h0, 32'h1);
    s_tvalid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || s_tready !== 1'b1) begin
      n_fail++; $display("FAIL midload_busy: busy=%b tready=%b expected 1 1", busy, s_tready);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, s_tready, buf_we, calc_en, m_tvalid, m_tlast} !== 6'b0) begin
      n_fail++;
      $display("FAIL midload_reset: busy=%b tready=%b we=%b calc=%b tvalid=%b tlast=%b expected 0",
               busy, s_tready, buf_we, calc_en, m_tvalid, m_tlast);
    end
    s_tvalid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    m_nload = DEPTH; m_nout = DEPTH; m_k = 1;
    n_checks++;
    if (out_q.size() != 0) begin
      n_fail++; $display("FAIL midload_no_output: beats=%0d expected 0", out_q.size());
    end
    wr_reg(32'h4, 32'd3); wr_reg(32'h8, 32'd5); wr_reg(32'hC, 32'd2);
    run_job(-1, -1, 0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int j = 0; j < 5; j++) begin
      int tl, sb;
      wr_reg(32'h4, 32'($urandom_range(0, 70)));
      wr_reg(32'h8, ($urandom_range(0, 3) == 0) ? 32'd70 : 32'($urandom_range(0, 12)));
      wr_reg(32'hC, 32'($urandom_range(0, 10)));
      tl = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 10)) : -1;
      sb = int'($urandom_range(0, 4));
      run_job(tl, sb, int'($urandom_range(0, 3)), 1'b0, "random");
    end
  endtask

  initial begin
    rst_n = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; bready = 1'b1;
    s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
    m_nload = DEPTH; m_nout = DEPTH; m_k = 1;
    first_tv_cyc = -1;
    #2 rst_n = 1'b0;
    test_reset();
    test_defaults();
    test_basic();
    test_stall();
    test_tlast_early();
    test_bresp_hold();
    test_start_during_busy();
    test_clamp();
    test_ctrl_bit1();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
